// File: rtl/irq_ctrl_pkg.sv
// Shared constants, types and helpers for the irq_ctrl interrupt controller.
package irq_ctrl_pkg;

  typedef logic [7:0] irq_vec_t;

  // Register offsets relative to IO_BASE
  localparam logic [2:0] OFF_STATUS = 3'd0;
  localparam logic [2:0] OFF_MASK   = 3'd1;
  localparam logic [2:0] OFF_CLEAR  = 3'd2;
  localparam logic [2:0] OFF_VECTOR = 3'd3;
  localparam logic [2:0] OFF_MODE   = 3'd4;

  localparam irq_vec_t VEC_NONE = 8'h80;
  localparam irq_vec_t MASK_RST = 8'hFF;  // everything masked out of reset
  localparam irq_vec_t MODE_RST = 8'hFF;  // everything edge-triggered out of reset

  // Returns {none, idx}: idx of the lowest set bit, none=1 when v is zero.
  function automatic logic [3:0] lowest_idx(input irq_vec_t v);
    lowest_idx = 4'b1000;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_idx = {1'b0, 3'(i)};
    end
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-stage synchroniser for the raw interrupt sources plus rising-edge detect.
// s is the last synchroniser stage; rise = s & ~(s one cycle earlier).
module irq_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int W           = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] src,
  output logic [W-1:0] s,
  output logic [W-1:0] rise
);

  logic [SYNC_STAGES-1:0][W-1:0] sync_q;  // [0] newest, [SYNC_STAGES-1] = s
  logic [W-1:0]                  s_d;

  // Shift sources through the synchroniser and keep one cycle of history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

endmodule

// File: rtl/irq_ctrl.sv
// 8-channel interrupt controller: synchronise, latch edge/level into pending,
// mask, and drive the CPU's external IRQ lines. IO-mapped register file at
// IO_BASE..IO_BASE+4 (STATUS, MASK, CLEAR, VECTOR, MODE).
// Build option IRQ_CTRL_PRIORITY_EN: irq_req carries only the lowest-index
// active request (one-hot or zero) instead of all active requests.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter logic [21:0] IO_BASE     = 22'h000040,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  irq_src,
  input  logic [21:0] addr,
  input  logic [7:0]  wdata,
  input  logic        rd,
  input  logic        wr,
  input  logic        mem_io,
  output logic [7:0]  rdata,
  output logic        rdata_vld,
  output logic [7:0]  irq_req
);

  irq_vec_t s, rise, set_v, clr_v, pend_nxt, active, req_nxt, vector;
  irq_vec_t pending, mask, mode, rd_val;
  logic       sel, wr_en, rd_en;
  logic [2:0] off;
  logic [3:0] low;

  irq_sync #(.SYNC_STAGES(SYNC_STAGES), .W(8)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .src   (irq_src),
    .s     (s),
    .rise  (rise)
  );

  // Inside the window the offset fits in 3 bits, so the low bits suffice.
  assign sel   = ~mem_io & (addr >= IO_BASE) & (addr <= IO_BASE + 22'd4);
  assign off   = addr[2:0] - IO_BASE[2:0];
  assign wr_en = wr & sel;
  assign rd_en = rd & sel;

  // Set/clear/next-pending, vector and request selection.
  always_comb begin
    set_v    = (mode & rise) | (~mode & s);
    clr_v    = (wr_en && off == OFF_CLEAR) ? wdata : '0;
    pend_nxt = set_v | (pending & ~clr_v);  // set wins over a coincident clear
    active   = pending & ~mask;
    low      = lowest_idx(active);
    vector   = low[3] ? VEC_NONE : {5'b0, low[2:0]};
`ifdef IRQ_CTRL_PRIORITY_EN
    req_nxt  = active & (~active + 8'd1);  // isolate lowest set bit
`else
    req_nxt  = active;
`endif
  end

  // Read mux: always reflects pre-write register state.
  always_comb begin
    rd_val = '0;
    case (off)
      OFF_STATUS: rd_val = pending;
      OFF_MASK:   rd_val = mask;
      OFF_VECTOR: rd_val = vector;
      OFF_MODE:   rd_val = mode;
      default:    rd_val = '0;
    endcase
  end

  // Register file, pending latch, registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      mask      <= MASK_RST;
      mode      <= MODE_RST;
      irq_req   <= '0;
      rdata     <= '0;
      rdata_vld <= 1'b0;
    end else begin
      pending   <= pend_nxt;
      irq_req   <= req_nxt;
      rdata_vld <= rd_en;
      rdata     <= rd_en ? rd_val : '0;
      if (wr_en && off == OFF_MASK) mask <= wdata;
      if (wr_en && off == OFF_MODE) mode <= wdata;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with a cycle-level reference model that is
// compared against the DUT outputs after every clock edge.
module tb_irq_ctrl;
  localparam logic [21:0] IO_BASE = 22'h000040;
  localparam int          SYNC    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq_src;
  logic [21:0] addr;
  logic [7:0]  wdata;
  logic        rd, wr, mem_io;
  logic [7:0]  rdata;
  logic        rdata_vld;
  logic [7:0]  irq_req;

  int checks = 0;
  int errors = 0;

  irq_ctrl #(.IO_BASE(IO_BASE), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .addr(addr), .wdata(wdata),
    .rd(rd), .wr(wr), .mem_io(mem_io), .rdata(rdata), .rdata_vld(rdata_vld),
    .irq_req(irq_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_q[$];          // sampled sources, oldest first
  logic [7:0] m_sd, m_pend, m_mask, m_mode;
  logic [7:0] e_irq, e_rdata;
  logic       e_vld;
  bit         m_init = 0;

  function automatic logic [7:0] one_hot_low(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 8'(1 << i);
    return 8'h00;
  endfunction

  function automatic logic [7:0] vec_of(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 8'(i);
    return 8'h80;
  endfunction

  always @(posedge clk) begin
    logic [7:0] sv, setv, clr, act, rv;
    int  a, off;
    bit  sel;
    if (!rst_n) begin
      m_q = {};
      for (int k = 0; k < SYNC; k++) m_q.push_back(8'h00);
      m_sd = 0; m_pend = 0; m_mask = 8'hFF; m_mode = 8'hFF;
      e_irq = 0; e_rdata = 0; e_vld = 0;
      m_init = 1;
    end else if (m_init) begin
      sv = m_q[0];
      for (int i = 0; i < 8; i++)
        setv[i] = m_mode[i] ? (sv[i] && !m_sd[i]) : sv[i];
      a   = int'(addr);
      sel = !mem_io && a >= int'(IO_BASE) && a <= int'(IO_BASE) + 4;
      off = a - int'(IO_BASE);
      act = m_pend & ~m_mask;
      case (off)
        0: rv = m_pend;
        1: rv = m_mask;
        3: rv = vec_of(act);
        4: rv = m_mode;
        default: rv = 8'h00;
      endcase
      e_vld   = rd && sel;
      e_rdata = e_vld ? rv : 8'h00;
`ifdef IRQ_CTRL_PRIORITY_EN
      e_irq = one_hot_low(act);
`else
      e_irq = act;
`endif
      clr = (wr && sel && off == 2) ? wdata : 8'h00;
      if (wr && sel && off == 1) m_mask = wdata;
      if (wr && sel && off == 4) m_mode = wdata;
      m_pend = setv | (m_pend & ~clr);
      m_sd = sv;
      void'(m_q.pop_front());
      m_q.push_back(irq_src);
    end
    #1;
    if (m_init) begin
      chk("model irq_req", irq_req, e_irq);
      chk("model rdata_vld", {7'b0, rdata_vld}, {7'b0, e_vld});
      chk("model rdata", rdata, e_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_read(input int off, output logic [7:0] d);
    @(negedge clk);
    addr = IO_BASE + 22'(off); mem_io = 1'b0; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0; d = rdata;
    chk("read vld", {7'b0, rdata_vld}, 8'h01);
  endtask

  task automatic do_write(input int off, input logic [7:0] v);
    @(negedge clk);
    addr = IO_BASE + 22'(off); mem_io = 1'b0; wdata = v; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] v);
    @(negedge clk); irq_src = v;
    @(negedge clk); irq_src = 8'h00;
  endtask

  initial begin
    logic [7:0] d;
    rst_n = 0; irq_src = 0; addr = 0; wdata = 0; rd = 0; wr = 0; mem_io = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Reset state
    chk("reset irq_req", irq_req, 8'h00);
    do_read(1, d); chk("reset MASK", d, 8'hFF);
    do_read(4, d); chk("reset MODE", d, 8'hFF);
    do_read(0, d); chk("reset STATUS", d, 8'h00);

    // Edge latch and latency
    do_write(1, 8'hFE);
    pulse(8'h01);
    @(negedge clk);
    @(negedge clk); chk("edge lat-1", irq_req, 8'h00);
    @(negedge clk); chk("edge lat", irq_req, 8'h01);
    do_read(0, d); chk("edge STATUS", d, 8'h01);
    do_read(3, d); chk("edge VECTOR", d, 8'h00);
    do_write(2, 8'h01); chk("clear +1", irq_req, 8'h01);
    @(negedge clk);     chk("clear +2", irq_req, 8'h00);

    // Level mode: clear while source high re-sets
    do_write(4, 8'hFB);
    do_write(1, 8'h00);
    @(negedge clk); irq_src = 8'h04;
    repeat (4) @(negedge clk);
    do_read(0, d); chk("level STATUS", d, 8'h04);
    do_write(2, 8'h04);
    do_read(0, d); chk("level clr held", d, 8'h04);
    irq_src = 8'h00;
    repeat (4) @(negedge clk);
    do_write(2, 8'h04);
    do_read(0, d); chk("level STATUS 0", d, 8'h00);
    do_read(3, d); chk("level VECTOR none", d, 8'h80);

    // Set/clear collision on bit 3
    pulse(8'h08);
    @(negedge clk); addr = IO_BASE + 22'd2; wdata = 8'h08; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
    do_read(0, d); chk("collision STATUS", d, 8'h08);
    do_write(2, 8'h08);
    do_read(0, d); chk("collision cleared", d, 8'h00);

    // Decode: memory cycle and out-of-window address
    @(negedge clk); mem_io = 1'b1; addr = IO_BASE + 22'd1; wdata = 8'h55; wr = 1; rd = 1;
    @(negedge clk); mem_io = 1'b0; addr = IO_BASE + 22'd5; wdata = 8'hAA;
    chk("decode mem vld", {7'b0, rdata_vld}, 8'h00);
    @(negedge clk); wr = 0; rd = 0;
    chk("decode +5 vld", {7'b0, rdata_vld}, 8'h00);
    do_read(1, d); chk("decode MASK", d, 8'h00);

    // Priority / parallel requests
    pulse(8'h0A);
    repeat (4) @(negedge clk);
`ifdef IRQ_CTRL_PRIORITY_EN
    chk("prio req", irq_req, 8'h02);
`else
    chk("prio req", irq_req, 8'h0A);
`endif
    do_read(3, d); chk("prio VECTOR", d, 8'h01);
    do_write(2, 8'h02);
    @(negedge clk); chk("prio next", irq_req, 8'h08);

    // Simultaneous rd+wr returns pre-write value
    @(negedge clk); addr = IO_BASE + 22'd1; wdata = 8'hFF; wr = 1; rd = 1;
    @(negedge clk); wr = 0; rd = 0;
    chk("rdwr pre-write", rdata, 8'h00);
    do_read(1, d); chk("rdwr MASK", d, 8'hFF);

    // Mid-operation reset drops the in-flight read
    @(negedge clk); addr = IO_BASE + 22'd4; rd = 1; rst_n = 0;
    @(negedge clk); rd = 0; rst_n = 1;
    chk("midrst vld", {7'b0, rdata_vld}, 8'h00);
    do_read(0, d); chk("midrst STATUS", d, 8'h00);
    do_read(4, d); chk("midrst MODE", d, 8'hFF);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
